hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

- Pipeline hazard and forwarding controller for the five-stage MIPS core.
- It produces the 2-bit select codes that drive the EX-stage `mux3` operand selectors: 00 = register file, 01 = WB result, 10 = MEM result.
- It generates the load-use and multi-cycle-divide stall/flush controls.
- It tracks in-flight destination registers itself in a shadow pipeline advanced by its own stall decisions, so the datapath supplies only decode-stage fields.

## Interface

Parameters:
- `DIV_CYCLES`, 32: EX-stage occupancy of a divide, in cycles; legal range 2..63.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_rs` in 5: source register A of the ID instruction.
- `id_rt` in 5: source register B of the ID instruction.
- `id_dst` in 5: destination register of the ID instruction.
- `id_regwrite` in 1: the ID instruction writes the register file.
- `id_memtoreg` in 1: the ID instruction is a load.
- `id_div` in 1: the ID instruction is a divide, multi-cycle in EX.
- `id_branch` in 1: the ID instruction is a branch compared in ID; used only with FWD_BRANCH_EN.
- `fwd_a_e` out 2: select for EX operand A `mux3`.
- `fwd_b_e` out 2: select for EX operand B `mux3`.
- `fwd_a_d` out 1: forward the MEM ALU result to ID branch-compare operand A.
- `fwd_b_d` out 1: forward the MEM ALU result to ID branch-compare operand B.
- `stall_f` out 1: hold the PC.
- `stall_d` out 1: hold the IF/ID register.
- `stall_e` out 1: hold the ID/EX register.
- `flush_e` out 1: load a bubble into ID/EX.
- `div_busy` out 1: a divide occupies EX and its counter is nonzero.

## Operation

- **Shadow pipeline:** the EX, MEM and WB slots each hold {valid, rs, rt, dst, regwrite, memtoreg, div}.
- **Per clock edge:**
  - If `stall_e`: EX holds; MEM is loaded invalid; WB takes MEM.
  - Else if `flush_e`: EX is loaded invalid; MEM takes EX; WB takes MEM.
  - Otherwise: ID→EX, EX→MEM, MEM→WB.
- **EX forwarding, operand A** (B is identical using rt):
  - 10 if MEM is valid, MEM.regwrite is set, MEM.dst ≠ 0 and MEM.dst == EX.rs.
  - Else 01 under the same test against WB.
  - Else 00.
  - MEM has priority over WB. Register 0 never forwards.
  - The select is combinational from slot state. It is 00 when EX is invalid.
- **Load-use hazard:** asserted when `id_valid` is set, EX is a valid load, EX.dst ≠ 0, and EX.dst equals `id_rs` or `id_rt`.
  - Response: `stall_f` = `stall_d` = `flush_e` = 1 for exactly one cycle.
- **Divide:**
  - When a div instruction enters EX, the counter loads DIV_CYCLES−1.
  - While EX.div is set and the counter ≠ 0: `div_busy` = `stall_f` = `stall_d` = `stall_e` = 1, and the counter decrements each edge.
  - At counter 0 the div leaves EX on the next edge. Total EX occupancy is DIV_CYCLES cycles.
- **Priority:** divide stall dominates. While `stall_e` is high, `flush_e` = 0 and the load-use term is masked. It is re-evaluated after the divide releases.
- **Arithmetic:** register comparisons are exact 5-bit equality. The counter is 6 bits and never wraps below 0.

## Timing

- **Reset:** all slots invalid, counter 0. All outputs 0, including `fwd_*` = 00.
- **Reset mid-operation:** reset during a divide or a stall clears everything on that edge. Outputs are 0 in the following cycle.
- **Stall latency:** stalls are combinational from the ID inputs and slot state, so they take effect in the same cycle as the hazard.
- **Forward-select latency:** selects are valid in the same cycle the consumer occupies EX.
- **Load-use sequence:** load in EX, dependent instruction in ID → one stall cycle. On the next cycle the load is in MEM and a bubble is in EX. The dependent instruction then enters EX with the load in WB and gets select 01.
- **Back-to-back divides:** the second divide reloads the counter when it enters EX. There is no idle gap beyond normal flow.
- **Simultaneous events:**
  - A load in WB and an ALU op in MEM both writing EX.rs → select 10.
  - `id_valid` = 0 suppresses the load-use stall.

## Configuration

- **Macro:** `HAZARD_FWD_BRANCH_EN`.
- **Defined:**
  - `fwd_a_d` = (`id_rs` ≠ 0, `id_rs` == MEM.dst, MEM.regwrite set, MEM valid). `fwd_b_d` is the same using rt.
  - Branch stall: `stall_f` = `stall_d` = `flush_e` = 1 when `id_branch` is set and either:
    - EX is valid, EX.regwrite is set, EX.dst ≠ 0 and EX.dst matches rs or rt; or
    - MEM is a valid load with a nonzero matching dst.
- **Undefined:** `fwd_a_d` = `fwd_b_d` = 0 constant, `id_branch` is ignored, and there is no branch stall logic.

## Test plan

- **Reset:** assert `rst` for 2 cycles with random inputs → all outputs 0 one cycle after; `fwd_a_e` = 00.
- **EX forwarding:**
  - `add $3` then `sub` reading $3 as rs → `fwd_a_e` = 10 in the sub's EX cycle.
  - With one unrelated instruction between them → 01.
  - Destination $0 → 00.
- **Load-use:** `lw $5` in EX, ID rt = 5 → `stall_f`/`stall_d`/`flush_e` high for one cycle; the consumer later sees `fwd_b_e` = 01.
- **Divide with DIV_CYCLES = 4:** `div_busy` high for 3 cycles, `stall_e` high for the same 3 cycles, and the div leaves EX after the 4th cycle. Assert `rst` on the 2nd busy cycle → `div_busy` = 0 on the next cycle.
- **Divide masking load-use:** a divide stalling while a load-use pattern exists → `flush_e` stays 0 during `div_busy`, then asserts once it releases.
- **Branch forwarding:**
  - With `HAZARD_FWD_BRANCH_EN`: branch in ID reading $7 with an ALU writer of $7 in MEM → `fwd_a_d` = 1; with the writer in EX → one stall cycle.
  - Without the macro: `fwd_a_d` = 0 and no stall.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: hazard and forwarding controller for the five-stage MIPS core.
// It keeps its own shadow copy of the EX/MEM/WB stages and advances that copy
// with its own stall and flush decisions. The datapath therefore only supplies
// the decode-stage fields.
//
// Optional feature: define HAZARD_FWD_BRANCH_EN to enable ID-stage branch
// operand forwarding and the branch stall. When it is undefined, fwd_a_d and
// fwd_b_d are tied to 0 and id_branch is ignored.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   id_valid                 ID stage holds a real instruction
//   id_rs/id_rt/id_dst       ID register fields (5 bits each)
//   id_regwrite/id_memtoreg  ID instruction writes the RF / is a load
//   id_div/id_branch         ID instruction is a divide / an ID-compared branch
//   fwd_a_e/fwd_b_e          EX operand mux3 selects (00 RF, 01 WB, 10 MEM)
//   fwd_a_d/fwd_b_d          forward MEM ALU result to ID branch compare
//   stall_f/stall_d/stall_e  hold PC, IF/ID, ID/EX
//   flush_e                  load a bubble into ID/EX
//   div_busy                 divide occupies EX with a nonzero counter
module hazard_fwd_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_dst,
  input  logic       id_regwrite,
  input  logic       id_memtoreg,
  input  logic       id_div,
  input  logic       id_branch,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       flush_e,
  output logic       div_busy
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 6;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dst;
    logic             regwrite;
    logic             memtoreg;
    logic             div;
  } slot_t;

  slot_t            r_ex;
  slot_t            r_mem;
  slot_t            r_wb;
  slot_t            w_id;
  logic [CNT_W-1:0] r_div_cnt;
  logic             w_div_busy;
  logic             w_load_use;
  logic             w_branch_haz;
  logic             w_hazard;
  logic             w_unused_bits;

  // A slot that will write register r (register 0 never counts).
  function automatic logic slot_writes(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid && s.regwrite && (s.dst != '0) && (s.dst == r);
  endfunction

  // EX operand source: MEM has priority over WB.
  function automatic logic [1:0] fwd_sel(input slot_t mem, input slot_t wb,
                                         input logic [REG_W-1:0] r);
    if (slot_writes(mem, r))     return 2'b10;
    else if (slot_writes(wb, r)) return 2'b01;
    else                         return 2'b00;
  endfunction

  assign w_id = '{valid: id_valid, rs: id_rs, rt: id_rt, dst: id_dst,
                  regwrite: id_regwrite, memtoreg: id_memtoreg, div: id_div};

  // Slot fields that only some build options consume.
  assign w_unused_bits = ^{r_ex, r_mem, r_wb, id_branch};

  // Hazard detection, stall/flush and forwarding selects.
  always_comb begin
    w_div_busy   = 1'b0;
    w_load_use   = 1'b0;
    w_branch_haz = 1'b0;
    w_hazard     = 1'b0;
    fwd_a_e      = 2'b00;
    fwd_b_e      = 2'b00;
    fwd_a_d      = 1'b0;
    fwd_b_d      = 1'b0;

    w_div_busy = r_ex.valid && r_ex.div && (r_div_cnt != '0);
    w_load_use = id_valid && r_ex.valid && r_ex.memtoreg && (r_ex.dst != '0) &&
                 ((r_ex.dst == id_rs) || (r_ex.dst == id_rt));

`ifdef HAZARD_FWD_BRANCH_EN
    fwd_a_d = slot_writes(r_mem, id_rs);
    fwd_b_d = slot_writes(r_mem, id_rt);
    // Branch compares in ID: an EX writer is too late to forward, and so is a MEM load.
    w_branch_haz = id_branch &&
                   (slot_writes(r_ex, id_rs) || slot_writes(r_ex, id_rt) ||
                    (r_mem.memtoreg && (slot_writes(r_mem, id_rs) ||
                                        slot_writes(r_mem, id_rt))));
`endif

    // The divide stall masks every other hazard until it releases.
    w_hazard = (w_load_use || w_branch_haz) && !w_div_busy;

    if (r_ex.valid) begin
      fwd_a_e = fwd_sel(r_mem, r_wb, r_ex.rs);
      fwd_b_e = fwd_sel(r_mem, r_wb, r_ex.rt);
    end
  end

  assign stall_e  = w_div_busy;
  assign flush_e  = w_hazard;
  assign stall_f  = w_div_busy || w_hazard;
  assign stall_d  = w_div_busy || w_hazard;
  assign div_busy = w_div_busy;

  // Shadow pipeline and divide counter, advanced by this block's own stall decisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex      <= '0;
      r_mem     <= '0;
      r_wb      <= '0;
      r_div_cnt <= '0;
    end else begin
      r_wb <= r_mem;
      if (w_div_busy) begin
        r_mem     <= '0;
        r_div_cnt <= r_div_cnt - CNT_W'(1);
      end else if (w_hazard) begin
        r_ex  <= '0;
        r_mem <= r_ex;
      end else begin
        r_ex  <= w_id;
        r_mem <= r_ex;
        if (id_valid && id_div) begin
          r_div_cnt <= CNT_W'(DIV_CYCLES - 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Testbench for hazard_fwd_ctrl: directed scenarios plus random traffic, with
// a stage-by-stage instruction model that derives the expected controls.
module tb_hazard_fwd_ctrl;

  localparam int DIV_N = 4;
`ifdef HAZARD_FWD_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_regwrite, id_memtoreg, id_div, id_branch;
  logic [4:0] id_rs, id_rt, id_dst;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       fwd_a_d, fwd_b_d, stall_f, stall_d, stall_e, flush_e, div_busy;
  logic [10:0] got;

  hazard_fwd_ctrl #(.DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
    .id_div(id_div), .id_branch(id_branch), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .flush_e(flush_e), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  assign got = {fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_f, stall_d, stall_e, flush_e, div_busy};

  typedef struct {
    bit       v;
    bit [4:0] rs, rt, dst;
    bit       rw, ld, dv;
  } ins_t;

  int          n_run = 0;
  int          n_fail = 0;
  ins_t        m_ex, m_mem, m_wb, cur;
  bit          cur_br;
  int          m_age;          // cycles the instruction in EX has already spent there
  bit          e_busy, e_haz;
  logic [10:0] exp_vec;

  function automatic ins_t mk(bit v, int rs, int rt, int dst, bit rw, bit ld, bit dv);
    ins_t i;
    i.v = v; i.rs = 5'(rs); i.rt = 5'(rt); i.dst = 5'(dst);
    i.rw = rw; i.ld = ld; i.dv = dv;
    return i;
  endfunction

  function automatic bit writes(input ins_t s, input bit [4:0] r);
    return s.v && s.rw && (s.dst != 5'd0) && (s.dst == r);
  endfunction

  function automatic bit [1:0] src_of(input bit [4:0] r);
    if (!m_ex.v)          return 2'd0;
    if (writes(m_mem, r)) return 2'd2;
    if (writes(m_wb, r))  return 2'd1;
    return 2'd0;
  endfunction

  // Expected controls for the current model state and ID instruction.
  task automatic compute_exp();
    bit lu, bh, fad, fbd;
    e_busy = m_ex.v && m_ex.dv && (m_age < DIV_N - 1);
    lu = cur.v && m_ex.v && m_ex.ld && (m_ex.dst != 0) &&
         ((m_ex.dst == cur.rs) || (m_ex.dst == cur.rt));
    bh = 0; fad = 0; fbd = 0;
    if (BR_EN) begin
      fad = writes(m_mem, cur.rs);
      fbd = writes(m_mem, cur.rt);
      bh  = cur_br && (writes(m_ex, cur.rs) || writes(m_ex, cur.rt) ||
                       (m_mem.ld && (writes(m_mem, cur.rs) || writes(m_mem, cur.rt))));
    end
    e_haz = (lu || bh) && !e_busy;
    exp_vec = {src_of(m_ex.rs), src_of(m_ex.rt), fad, fbd, e_busy || e_haz,
               e_busy || e_haz, e_busy, e_haz, e_busy};
  endtask

  task automatic apply(input ins_t i, input bit br, input bit r);
    cur = i; cur_br = br;
    rst = r; id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_dst = i.dst;
    id_regwrite = i.rw; id_memtoreg = i.ld; id_div = i.dv; id_branch = br;
    @(negedge clk);
    compute_exp();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_ex = mk(0,0,0,0,0,0,0); m_mem = m_ex; m_wb = m_ex; m_age = 0;
    end else if (e_busy) begin
      m_wb = m_mem; m_mem = mk(0,0,0,0,0,0,0); m_age++;
    end else if (e_haz) begin
      m_wb = m_mem; m_mem = m_ex; m_ex = mk(0,0,0,0,0,0,0); m_age = 0;
    end else begin
      m_wb = m_mem; m_mem = m_ex; m_ex = cur; m_age = 0;
    end
    #1;
  endtask

  task automatic drain();
    repeat (8) begin apply(mk(0,0,0,0,0,0,0), 0, 0); tick(); end
  endtask

  function automatic ins_t rnd_ins();
    ins_t i;
    i.v  = ($urandom_range(3) != 0);
    i.rs = 5'($urandom_range(7)); i.rt = 5'($urandom_range(7)); i.dst = 5'($urandom_range(7));
    i.ld = ($urandom_range(3) == 0);
    i.rw = i.ld || ($urandom_range(1) == 1);
    i.dv = ($urandom_range(11) == 0);
    return i;
  endfunction

  task automatic test_reset();
    repeat (2) begin apply(rnd_ins(), 1'($urandom_range(1)), 1); tick(); end
    apply(rnd_ins(), 1'($urandom_range(1)), 0);
    n_run++;
    if (got !== 11'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=%b", got, 11'd0);
    end
    tick();
  endtask

  task automatic test_ex_forwarding();
    ins_t    sc[4][4];
    int      at[4];
    bit [1:0] want[4];
    sc[0][0] = mk(1,1,2,3,1,0,0); sc[0][1] = mk(1,3,4,6,1,0,0);   // add $3 ; sub rs=$3
    sc[0][2] = mk(0,0,0,0,0,0,0); sc[0][3] = mk(0,0,0,0,0,0,0);
    at[0] = 2; want[0] = 2'b10;
    sc[1][0] = mk(1,1,2,3,1,0,0); sc[1][1] = mk(1,9,10,8,1,0,0);  // one unrelated between
    sc[1][2] = mk(1,3,4,6,1,0,0); sc[1][3] = mk(0,0,0,0,0,0,0);
    at[1] = 3; want[1] = 2'b01;
    sc[2][0] = mk(1,1,2,0,1,0,0); sc[2][1] = mk(1,0,4,6,1,0,0);   // writer of $0
    sc[2][2] = mk(0,0,0,0,0,0,0); sc[2][3] = mk(0,0,0,0,0,0,0);
    at[2] = 2; want[2] = 2'b00;
    sc[3][0] = mk(1,1,0,3,1,1,0); sc[3][1] = mk(1,1,2,3,1,0,0);   // lw $3, add $3: MEM wins
    sc[3][2] = mk(1,3,4,6,1,0,0); sc[3][3] = mk(0,0,0,0,0,0,0);
    at[3] = 3; want[3] = 2'b10;
    for (int s = 0; s < 4; s++) begin
      drain();
      for (int c = 0; c < 4; c++) begin
        apply(sc[s][c], 0, 0);
        n_run++;
        if (got !== exp_vec) begin
          n_fail++; $display("FAIL exfwd_model s=%0d c=%0d got=%b exp=%b", s, c, got, exp_vec);
        end
        if (c == at[s]) begin
          n_run++;
          if (fwd_a_e !== want[s]) begin
            n_fail++; $display("FAIL exfwd_sel s=%0d got=%b exp=%b", s, fwd_a_e, want[s]);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_load_use();
    ins_t lw5, cons;
    lw5  = mk(1,1,0,5,1,1,0);
    cons = mk(1,6,5,7,1,0,0);
    drain();
    apply(lw5, 0, 0); tick();
    apply(cons, 0, 0);
    n_run++;
    if ({stall_f, stall_d, stall_e, flush_e} !== 4'b1101) begin
      n_fail++; $display("FAIL loaduse_stall got=%b exp=1101", {stall_f, stall_d, stall_e, flush_e});
    end
    tick();
    apply(cons, 0, 0);
    n_run++;
    if ({stall_f, stall_d, stall_e, flush_e} !== 4'b0000) begin
      n_fail++; $display("FAIL loaduse_release got=%b exp=0000", {stall_f, stall_d, stall_e, flush_e});
    end
    tick();
    apply(mk(0,0,0,0,0,0,0), 0, 0);
    n_run++;
    if ({fwd_a_e, fwd_b_e} !== 4'b0001) begin
      n_fail++; $display("FAIL loaduse_fwd got=%b exp=0001", {fwd_a_e, fwd_b_e});
    end
    tick();
    // Same pattern with id_valid low: no stall.
    drain();
    apply(lw5, 0, 0); tick();
    apply(mk(0,6,5,7,1,0,0), 0, 0);
    n_run++;
    if ({stall_f, flush_e} !== 2'b00) begin
      n_fail++; $display("FAIL loaduse_invalid got=%b exp=00", {stall_f, flush_e});
    end
    tick();
  endtask

  task automatic test_divide();
    int busy_n, ste_n;
    ins_t dv, add;
    dv  = mk(1,1,2,0,0,0,1);
    add = mk(1,10,11,9,1,0,0);
    drain();
    busy_n = 0; ste_n = 0;
    apply(dv, 0, 0); tick();
    for (int c = 0; c < 5; c++) begin
      apply(add, 0, 0);
      n_run++;
      if (got !== exp_vec) begin
        n_fail++; $display("FAIL div_model c=%0d got=%b exp=%b", c, got, exp_vec);
      end
      busy_n += int'(div_busy); ste_n += int'(stall_e);
      tick();
    end
    n_run++;
    if (busy_n != 3 || ste_n != 3) begin
      n_fail++; $display("FAIL div_len busy=%0d stall_e=%0d exp=3/3", busy_n, ste_n);
    end
    // Reset on the second busy cycle.
    drain();
    apply(dv, 0, 0); tick();
    apply(add, 0, 0); tick();
    apply(add, 0, 1);
    n_run++;
    if (div_busy !== 1'b1) begin
      n_fail++; $display("FAIL div_busy2 got=%b exp=1", div_busy);
    end
    tick();
    apply(add, 0, 0);
    n_run++;
    if (got !== 11'd0) begin
      n_fail++; $display("FAIL div_reset got=%b exp=%b", got, 11'd0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int   busy_n;
    bit   sent;
    bit   pat[8];
    ins_t dv;
    dv = mk(1,1,2,0,0,0,1);
    drain();
    apply(dv, 0, 0); tick();
    busy_n = 0; sent = 0;
    for (int c = 0; c < 8; c++) begin
      apply(sent ? mk(0,0,0,0,0,0,0) : dv, 0, 0);
      n_run++;
      if (got !== exp_vec) begin
        n_fail++; $display("FAIL b2b_model c=%0d got=%b exp=%b", c, got, exp_vec);
      end
      pat[c] = div_busy;
      busy_n += int'(div_busy);
      if (!e_busy && !e_haz) sent = 1;
      tick();
    end
    n_run++;
    if (busy_n != 6 || pat[3] || !pat[4]) begin
      n_fail++; $display("FAIL b2b_busy count=%0d gap=%b restart=%b exp=6/0/1", busy_n, pat[3], pat[4]);
    end
  endtask

  task automatic test_div_mask_load_use();
    ins_t dl, cons;
    dl   = mk(1,1,2,5,1,1,1);   // divide that also writes $5 as a load
    cons = mk(1,5,6,7,1,0,0);
    drain();
    apply(dl, 0, 0); tick();
    for (int c = 0; c < 6; c++) begin
      apply(cons, 0, 0);
      n_run++;
      if (got !== exp_vec) begin
        n_fail++; $display("FAIL mask_model c=%0d got=%b exp=%b", c, got, exp_vec);
      end
      if (c < 3) begin
        n_run++;
        if (flush_e !== 1'b0 || div_busy !== 1'b1) begin
          n_fail++; $display("FAIL mask_busy c=%0d flush=%b busy=%b exp=0/1", c, flush_e, div_busy);
        end
      end else if (c == 3) begin
        n_run++;
        if (flush_e !== 1'b1 || stall_e !== 1'b0) begin
          n_fail++; $display("FAIL mask_release flush=%b stall_e=%b exp=1/0", flush_e, stall_e);
        end
      end
      tick();
    end
  endtask

  task automatic test_branch();
    ins_t add7, br;
    add7 = mk(1,1,2,7,1,0,0);
    br   = mk(1,7,0,0,0,0,0);
    drain();
    apply(add7, 0, 0); tick();
    apply(mk(1,9,10,8,1,0,0), 0, 0); tick();
    apply(br, 1, 0);
    n_run++;
    if ({fwd_a_d, stall_f} !== {BR_EN, 1'b0}) begin
      n_fail++; $display("FAIL br_mem got=%b exp=%b", {fwd_a_d, stall_f}, {BR_EN, 1'b0});
    end
    tick();
    drain();
    apply(add7, 0, 0); tick();
    apply(br, 1, 0);
    n_run++;
    if ({stall_f, stall_d, flush_e} !== {BR_EN, BR_EN, BR_EN}) begin
      n_fail++; $display("FAIL br_ex got=%b exp=%b", {stall_f, stall_d, flush_e}, {BR_EN, BR_EN, BR_EN});
    end
    tick();
    apply(br, 1, 0);
    n_run++;
    if (got !== exp_vec) begin
      n_fail++; $display("FAIL br_after got=%b exp=%b", got, exp_vec);
    end
    tick();
  endtask

  task automatic test_random();
    ins_t i;
    bit   held, br;
    i = rnd_ins(); br = 0; held = 0;
    for (int c = 0; c < 400; c++) begin
      if (!held) begin i = rnd_ins(); br = ($urandom_range(3) == 0); end
      apply(i, br, ($urandom_range(49) == 0));
      n_run++;
      if (got !== exp_vec) begin
        n_fail++; $display("FAIL random c=%0d got=%b exp=%b", c, got, exp_vec);
      end
      held = (e_busy || e_haz) && !rst;
      tick();
    end
  endtask

  initial begin
    m_ex = mk(0,0,0,0,0,0,0); m_mem = m_ex; m_wb = m_ex; m_age = 0;
    cur = m_ex; cur_br = 0;
    rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0;
    id_regwrite = 0; id_memtoreg = 0; id_div = 0; id_branch = 0;
    test_reset();
    test_ex_forwarding();
    test_load_use();
    test_divide();
    test_back_to_back();
    test_div_mask_load_use();
    test_branch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
